// File: rtl/output_stream_tx.sv
// Result transmit path: buffers requantized accumulator results and streams them onto the shared con_* bus.
// Optional OUTPUT_ROUND_EN macro selects round-half-up before the shift; undefined gives a truncating shift.
//
// state     | meaning
// S_IDLE    | bus released, waiting for bus_grant with data buffered
// S_TURN    | bus owned, one turnaround cycle before driving beats
// S_STREAM  | bus owned, con_valid follows buffer occupancy
// S_RELEASE | bus still owned for one turnaround cycle before IDLE

module output_stream_tx #(
   parameter int IO_DATA_WIDTH      = 16,
   parameter int ACCUMULATION_WIDTH = 32,
   parameter int FEATURE_MAP_WIDTH  = 64,
   parameter int FEATURE_MAP_HEIGHT = 64,
   parameter int OUTPUT_NB_CHANNELS = 32,
   parameter int FIFO_DEPTH         = 8,
   parameter int OUT_SHIFT          = 8
) (
   input  logic                                    clk,
   input  logic                                    arst_n_in,
   input  logic                                    acc_valid,
   output logic                                    acc_ready,
   input  logic [ACCUMULATION_WIDTH-1:0]           acc_data,
   input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    acc_x,
   input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   acc_y,
   input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   acc_ch,
   input  logic                                    bus_grant,
   output logic [IO_DATA_WIDTH-1:0]                con_1,
   output logic [IO_DATA_WIDTH-1:0]                con_2,
   output logic [IO_DATA_WIDTH-1:0]                con_3,
   output logic                                    con_valid,
   input  logic                                    con_ready,
   output logic                                    output_valid,
   output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    output_x,
   output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   output_y,
   output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   output_ch,
   output logic                                    driving_cons,
   output logic                                    tx_idle
);
   localparam int XW  = $clog2(FEATURE_MAP_WIDTH);
   localparam int YW  = $clog2(FEATURE_MAP_HEIGHT);
   localparam int CW  = $clog2(OUTPUT_NB_CHANNELS);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int IOW = IO_DATA_WIDTH;
   localparam int SW  = ACCUMULATION_WIDTH + 1;
   localparam int EW  = IOW + XW + YW + CW;

   localparam logic signed [SW-1:0] SAT_MAX = (SW'(1) << (IOW-1)) - SW'(1);
   localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;
   localparam logic [IOW-1:0]       Q_MAX   = {1'b0, {(IOW-1){1'b1}}};
   localparam logic [IOW-1:0]       Q_MIN   = {1'b1, {(IOW-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_TURN, S_STREAM, S_RELEASE} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [EW-1:0]       r_mem [FIFO_DEPTH];
   logic [AW:0]         r_wr_ptr;
   logic [AW:0]         r_rd_ptr;
   logic                w_empty;
   logic                w_full;
   logic                w_push;
   logic                w_pop;
   logic                w_last;
   logic                w_empty_nxt;
   logic signed [SW-1:0] w_ext;
   logic signed [SW-1:0] w_sum;
   logic signed [SW-1:0] w_shift;
   logic [IOW-1:0]      w_q;
   logic [EW-1:0]       w_head;

   // One extra sign bit keeps the rounding add from wrapping before saturation.
   assign w_ext = {acc_data[ACCUMULATION_WIDTH-1], acc_data};
`ifdef OUTPUT_ROUND_EN
   assign w_sum = w_ext + ((SW'(1) << OUT_SHIFT) >> 1);
`else
   assign w_sum = w_ext;
`endif
   assign w_shift = w_sum >>> OUT_SHIFT;

   always_comb begin
      if (w_shift > SAT_MAX)
         w_q = Q_MAX;
      else if (w_shift < SAT_MIN)
         w_q = Q_MIN;
      else
         w_q = w_shift[IOW-1:0];
   end

   assign w_empty     = (r_wr_ptr == r_rd_ptr);
   assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push      = acc_valid & ~w_full;
   assign w_pop       = con_valid & con_ready;
   assign w_last      = ((r_wr_ptr - r_rd_ptr) == (AW+1)'(1));
   assign w_empty_nxt = ~w_push & (w_empty | (w_pop & w_last));

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {w_q, acc_x, acc_y, acc_ch};
            r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
   assign con_1     = w_head[EW-1 -: IOW];
   assign output_x  = w_head[CW+YW +: XW];
   assign output_y  = w_head[CW +: YW];
   assign output_ch = w_head[CW-1:0];
   assign con_2     = {{(IOW-XW){1'b0}}, output_x};
   assign con_3     = {{(IOW-CW){1'b0}}, output_ch};

   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) r_state <= S_IDLE;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (bus_grant & ~w_empty) w_state_nxt = S_TURN;
         S_TURN:    w_state_nxt = S_STREAM;
         // A pending unaccepted beat holds the bus even after bus_grant drops.
         S_STREAM:  if (w_empty_nxt | (~bus_grant & (~con_valid | w_pop))) w_state_nxt = S_RELEASE;
         S_RELEASE: w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      driving_cons = 1'b0;
      con_valid    = 1'b0;
      case (r_state)
         S_TURN:   driving_cons = 1'b1;
         S_STREAM: begin
            driving_cons = 1'b1;
            con_valid    = ~w_empty;
         end
         default: ;
      endcase
   end

   assign output_valid = con_valid & con_ready;
   assign acc_ready    = ~w_full;
   assign tx_idle      = (r_state == S_IDLE) & w_empty;

endmodule

// File: tb/tb_output_stream_tx.sv
// Randomized and directed bench for output_stream_tx against a queue-based reference model.
module tb_output_stream_tx;
   localparam int SH = 8;

   logic        clk = 1'b0;
   logic        arst_n_in = 1'b0;
   logic        acc_valid = 1'b0;
   logic        acc_ready;
   logic [31:0] acc_data = '0;
   logic [5:0]  acc_x = '0, acc_y = '0;
   logic [4:0]  acc_ch = '0;
   logic        bus_grant = 1'b0;
   logic [15:0] con_1, con_2, con_3;
   logic        con_valid;
   logic        con_ready = 1'b0;
   logic        output_valid;
   logic [5:0]  output_x, output_y;
   logic [4:0]  output_ch;
   logic        driving_cons;
   logic        tx_idle;

   int cmp = 0;
   int mis = 0;
   logic [53:0] exp_q[$];

   output_stream_tx dut (
      .clk(clk), .arst_n_in(arst_n_in), .acc_valid(acc_valid), .acc_ready(acc_ready),
      .acc_data(acc_data), .acc_x(acc_x), .acc_y(acc_y), .acc_ch(acc_ch),
      .bus_grant(bus_grant), .con_1(con_1), .con_2(con_2), .con_3(con_3),
      .con_valid(con_valid), .con_ready(con_ready), .output_valid(output_valid),
      .output_x(output_x), .output_y(output_y), .output_ch(output_ch),
      .driving_cons(driving_cons), .tx_idle(tx_idle));

   always #5 clk = ~clk;

   // Expected beat as observed on {con_1, con_2, con_3, output_y}.
   function automatic logic [53:0] exp_beat(input logic [31:0] d, input logic [5:0] x,
                                            input logic [5:0] y, input logic [4:0] ch);
      longint s;
      logic [15:0] v;
      s = longint'($signed(d));
`ifdef OUTPUT_ROUND_EN
      s = s + (longint'(1) <<< (SH-1));
`endif
      s = s >>> SH;
      if (s > 32767) v = 16'h7FFF;
      else if (s < -32768) v = 16'h8000;
      else v = s[15:0];
      return {v, 10'd0, x, 11'd0, ch, y};
   endfunction

   function automatic logic [53:0] obs();
      return {con_1, con_2, con_3, output_y};
   endfunction

   task automatic push_beat(input logic [31:0] d, input logic [5:0] x, input logic [5:0] y, input logic [4:0] ch);
      @(negedge clk);
      acc_valid = 1'b1; acc_data = d; acc_x = x; acc_y = y; acc_ch = ch;
      #1;
      if (acc_ready) exp_q.push_back(exp_beat(d, x, y, ch));
      @(posedge clk);
      #1 acc_valid = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      logic ok;
      ok = 1'b0;
      for (int k = 0; k < 100 && !ok; k++) begin
         @(negedge clk); #1;
         if (tx_idle) ok = 1'b1;
      end
      cmp++; if (!ok) begin mis++; $display("FAIL %s_idle_timeout got=0 exp=1", nm); end
   endtask

   task automatic test_reset;
      #1;
      cmp++; if ({acc_ready, tx_idle, driving_cons, con_valid, output_valid} !== 5'b11000) begin
         mis++; $display("FAIL rst_flags got=%b exp=11000", {acc_ready, tx_idle, driving_cons, con_valid, output_valid}); end
      cmp++; if ({con_1, con_2, con_3} !== 48'd0) begin
         mis++; $display("FAIL rst_con got=%h exp=0", {con_1, con_2, con_3}); end
      repeat (2) @(negedge clk);
      arst_n_in = 1'b1;
      #1;
      cmp++; if ({acc_ready, tx_idle, driving_cons} !== 3'b110) begin
         mis++; $display("FAIL rst_after got=%b exp=110", {acc_ready, tx_idle, driving_cons}); end
   endtask

   task automatic test_directed;
      logic [53:0] e;
      bus_grant = 1'b1; con_ready = 1'b1;
      e = exp_beat(32'h0000_1280, 6'd3, 6'd5, 5'd7);
      push_beat(32'h0000_1280, 6'd3, 6'd5, 5'd7);
      @(negedge clk); #1;
      cmp++; if ({driving_cons, con_valid} !== 2'b00) begin mis++; $display("FAIL dir_c0 got=%b exp=00", {driving_cons, con_valid}); end
      @(negedge clk); #1;
      cmp++; if ({driving_cons, con_valid} !== 2'b10) begin mis++; $display("FAIL dir_turn got=%b exp=10", {driving_cons, con_valid}); end
      @(negedge clk); #1;
      cmp++; if ({driving_cons, con_valid, output_valid} !== 3'b111) begin mis++; $display("FAIL dir_stream got=%b exp=111", {driving_cons, con_valid, output_valid}); end
      cmp++; if (obs() !== e) begin mis++; $display("FAIL dir_beat got=%h exp=%h", obs(), e); end
`ifndef OUTPUT_ROUND_EN
      cmp++; if (con_1 !== 16'h0012) begin mis++; $display("FAIL dir_con1 got=%h exp=0012", con_1); end
`endif
      void'(exp_q.pop_front());
      @(negedge clk); #1;
      cmp++; if ({driving_cons, con_valid, tx_idle} !== 3'b000) begin mis++; $display("FAIL dir_release got=%b exp=000", {driving_cons, con_valid, tx_idle}); end
      @(negedge clk); #1;
      cmp++; if ({driving_cons, tx_idle} !== 2'b01) begin mis++; $display("FAIL dir_idle got=%b exp=01", {driving_cons, tx_idle}); end
   endtask

   task automatic test_requant;
      logic [31:0] din [3];
      logic [15:0] dexp [3];
      logic got;
      din[0] = 32'h7FFF_FFFF; dexp[0] = 16'h7FFF;
      din[1] = 32'h8000_0000; dexp[1] = 16'h8000;
      din[2] = 32'h0000_0180;
`ifdef OUTPUT_ROUND_EN
      dexp[2] = 16'h0002;
`else
      dexp[2] = 16'h0001;
`endif
      bus_grant = 1'b1; con_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_beat(din[i], 6'(i), 6'(i+1), 5'(i+2));
         got = 1'b0;
         for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk); #1;
            if (output_valid) begin
               got = 1'b1;
               cmp++; if (con_1 !== dexp[i]) begin mis++; $display("FAIL rq_val%0d got=%h exp=%h", i, con_1, dexp[i]); end
               void'(exp_q.pop_front());
            end
         end
         cmp++; if (!got) begin mis++; $display("FAIL rq_timeout%0d got=0 exp=1", i); end
         wait_idle("rq");
      end
   endtask

   task automatic test_full;
      logic e, done9;
      int nrx;
      bus_grant = 1'b1; con_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         acc_valid = 1'b1; acc_data = $urandom; acc_x = 6'(i); acc_y = 6'($urandom); acc_ch = 5'($urandom);
         #1;
         e = (i < 8);
         cmp++; if (acc_ready !== e) begin mis++; $display("FAIL full_ready%0d got=%b exp=%b", i, acc_ready, e); end
         if (acc_ready) exp_q.push_back(exp_beat(acc_data, acc_x, acc_y, acc_ch));
      end
      nrx = 0; done9 = 1'b0;
      for (int k = 0; k < 40 && nrx < 9; k++) begin
         @(negedge clk);
         if (k == 0) con_ready = 1'b1;
         if (done9) acc_valid = 1'b0;
         #1;
         if (acc_valid && acc_ready && !done9) begin
            exp_q.push_back(exp_beat(acc_data, acc_x, acc_y, acc_ch));
            done9 = 1'b1;
         end
         if (output_valid) begin
            cmp++; if (exp_q.size() == 0 || obs() !== exp_q[0]) begin
               mis++; $display("FAIL full_beat%0d got=%h exp=%h", nrx, obs(), exp_q.size() ? exp_q[0] : 54'd0); end
            if (exp_q.size()) void'(exp_q.pop_front());
            nrx++;
         end
      end
      acc_valid = 1'b0;
      cmp++; if (nrx != 9) begin mis++; $display("FAIL full_count got=%0d exp=9", nrx); end
      wait_idle("full");
   endtask

   task automatic test_grant_drop;
      logic [53:0] snap;
      logic got;
      bus_grant = 1'b1; con_ready = 1'b0;
      push_beat($urandom, 6'd10, 6'd11, 5'd12);
      push_beat($urandom, 6'd20, 6'd21, 5'd22);
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(negedge clk); #1;
         if (con_valid) got = 1'b1;
      end
      cmp++; if (!got) begin mis++; $display("FAIL gd_valid_timeout got=0 exp=1"); end
      snap = obs();
      @(negedge clk); bus_grant = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         cmp++; if ({con_valid, driving_cons} !== 2'b11 || obs() !== snap) begin
            mis++; $display("FAIL gd_hold%0d got=%b/%h exp=11/%h", k, {con_valid, driving_cons}, obs(), snap); end
      end
      @(negedge clk); con_ready = 1'b1; #1;
      cmp++; if (output_valid !== 1'b1 || obs() !== exp_q[0]) begin
         mis++; $display("FAIL gd_accept got=%b/%h exp=1/%h", output_valid, obs(), exp_q[0]); end
      void'(exp_q.pop_front());
      @(negedge clk); con_ready = 1'b0; #1;
      cmp++; if ({driving_cons, con_valid} !== 2'b00) begin mis++; $display("FAIL gd_release got=%b exp=00", {driving_cons, con_valid}); end
      @(negedge clk); #1;
      cmp++; if ({driving_cons, tx_idle} !== 2'b00) begin mis++; $display("FAIL gd_idle got=%b exp=00", {driving_cons, tx_idle}); end
      bus_grant = 1'b1; con_ready = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(negedge clk); #1;
         if (output_valid) begin
            got = 1'b1;
            cmp++; if (obs() !== exp_q[0]) begin mis++; $display("FAIL gd_second got=%h exp=%h", obs(), exp_q[0]); end
            void'(exp_q.pop_front());
         end
      end
      cmp++; if (!got) begin mis++; $display("FAIL gd_second_timeout got=0 exp=1"); end
      wait_idle("gd");
   endtask

   task automatic test_random;
      logic        prev_pend;
      logic [53:0] prev_obs;
      logic        e_ready;
      int          nrx;
      prev_pend = 1'b0; prev_obs = '0; nrx = 0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (c < 500) begin
            acc_valid = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 5))
               0: acc_data = 32'h7FFF_FFFF;
               1: acc_data = 32'h8000_0000;
               2: acc_data = $urandom_range(0, 1023) - 512;
               default: acc_data = $urandom;
            endcase
            acc_x = 6'($urandom); acc_y = 6'($urandom); acc_ch = 5'($urandom);
            bus_grant = ($urandom_range(0, 4) != 0);
            con_ready = ($urandom_range(0, 4) < 3);
         end else begin
            acc_valid = 1'b0; bus_grant = 1'b1; con_ready = 1'b1;
         end
         #1;
         e_ready = (exp_q.size() < 8);
         cmp++; if (acc_ready !== e_ready) begin mis++; $display("FAIL rnd_ready c%0d got=%b exp=%b", c, acc_ready, e_ready); end
         if (con_valid) begin
            cmp++; if (driving_cons !== 1'b1) begin mis++; $display("FAIL rnd_drv c%0d got=0 exp=1", c); end
         end
         if (prev_pend) begin
            cmp++; if (con_valid !== 1'b1 || obs() !== prev_obs) begin
               mis++; $display("FAIL rnd_stable c%0d got=%b/%h exp=1/%h", c, con_valid, obs(), prev_obs); end
         end
         if (output_valid) begin
            cmp++; if (exp_q.size() == 0 || obs() !== exp_q[0]) begin
               mis++; $display("FAIL rnd_beat c%0d got=%h exp=%h", c, obs(), exp_q.size() ? exp_q[0] : 54'd0); end
            if (exp_q.size()) void'(exp_q.pop_front());
            nrx++;
         end
         if (acc_valid && acc_ready) exp_q.push_back(exp_beat(acc_data, acc_x, acc_y, acc_ch));
         prev_pend = con_valid & ~con_ready;
         prev_obs  = obs();
      end
      cmp++; if (exp_q.size() != 0 || nrx == 0) begin mis++; $display("FAIL rnd_drain left=%0d rx=%0d exp=0/>0", exp_q.size(), nrx); end
      wait_idle("rnd");
   endtask

   task automatic test_async_reset;
      logic got, stale;
      exp_q.delete();
      bus_grant = 1'b1; con_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_beat($urandom, 6'(i), 6'(i), 5'(i));
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
         @(negedge clk); #1;
         if (con_valid) got = 1'b1;
      end
      cmp++; if (!got) begin mis++; $display("FAIL ar_valid_timeout got=0 exp=1"); end
      @(negedge clk); #2;
      arst_n_in = 1'b0;
      #1;
      cmp++; if ({driving_cons, con_valid, output_valid, acc_ready, tx_idle} !== 5'b00011) begin
         mis++; $display("FAIL ar_flags got=%b exp=00011", {driving_cons, con_valid, output_valid, acc_ready, tx_idle}); end
      cmp++; if ({con_1, con_2, con_3, output_x, output_y, output_ch} !== '0) begin
         mis++; $display("FAIL ar_data got=%h exp=0", {con_1, con_2, con_3, output_x, output_y, output_ch}); end
      exp_q.delete();
      @(negedge clk); arst_n_in = 1'b1; con_ready = 1'b1;
      stale = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); #1;
         if (con_valid || output_valid || driving_cons) stale = 1'b1;
      end
      cmp++; if (stale) begin mis++; $display("FAIL ar_stale got=1 exp=0"); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_requant();
      test_full();
      test_grant_drop();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
      $finish;
   end
endmodule
